// File: rtl/draw_pkg.sv
// Shared drawing definitions: draw modes, default coordinate width and
// the rasterizer state encoding.
package draw_pkg;

    localparam int COORD_W = 8;

    localparam logic [1:0] MODE_FREEHAND = 2'd0;
    localparam logic [1:0] MODE_LINE     = 2'd1;
    localparam logic [1:0] MODE_RECT     = 2'd2;
    localparam logic [1:0] MODE_SPRAY    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LINE,
        R_TOP,
        R_RIGHT,
        R_BOT,
        R_LEFT,
        FIN
    } state_t;

endpackage

// File: rtl/shape_raster_if.sv
// Pixel stream towards the framebuffer write path (valid/ready).
interface shape_raster_if
    import draw_pkg::*;
#(
    parameter int W = COORD_W
);

    logic [W-1:0] px_x;
    logic [W-1:0] px_y;
    logic         px_valid;
    logic         px_ready;

    modport master (
        output px_x,
        output px_y,
        output px_valid,
        input  px_ready
    );

    modport slave (
        input  px_x,
        input  px_y,
        input  px_valid,
        output px_ready
    );

endinterface

// File: rtl/shape_raster_line_stepper.sv
// Bresenham core: load endpoints, then advance one pixel per step.
module line_stepper
    import draw_pkg::*;
#(
    parameter int W = COORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         at_end
);

    localparam int SW = W + 2;

    logic [W-1:0]         ex;
    logic [W-1:0]         ey;
    logic [W-1:0]         ux;
    logic [W-1:0]         uy;
    logic                 sx_neg;
    logic                 sy_neg;
    logic                 mx;
    logic                 my;
    logic signed [SW-1:0] dx;
    logic signed [SW-1:0] dy;
    logic signed [SW-1:0] err;
    logic signed [SW-1:0] e2;
    logic signed [SW-1:0] err_n;
    logic signed [SW-1:0] adx;
    logic signed [SW-1:0] ady;
    logic [W-1:0]         nx;
    logic [W-1:0]         ny;

    always_comb begin
        ux  = (x1 >= x0) ? x1 - x0 : x0 - x1;
        uy  = (y1 >= y0) ? y1 - y0 : y0 - y1;
        adx = $signed({2'b00, ux});
        ady = $signed({2'b00, uy});
    end

    // Both moves are judged against the same e2, as in textbook Bresenham.
    always_comb begin
        e2    = err <<< 1;
        mx    = (e2 >= dy);
        my    = (e2 <= dx);
        err_n = err;
        nx    = x;
        ny    = y;
        if (mx) begin
            err_n = err_n + dy;
            nx    = sx_neg ? x - 1'b1 : x + 1'b1;
        end
        if (my) begin
            err_n = err_n + dx;
            ny    = sy_neg ? y - 1'b1 : y + 1'b1;
        end
    end

    assign at_end = (x == ex) && (y == ey);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            ex     <= '0;
            ey     <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else if (load) begin
            x      <= x0;
            y      <= y0;
            ex     <= x1;
            ey     <= y1;
            dx     <= adx;
            dy     <= -ady;
            err    <= adx - ady;
            sx_neg <= (x1 < x0);
            sy_neg <= (y1 < y0);
        end else if (step) begin
            x      <= nx;
            y      <= ny;
            err    <= err_n;
        end
    end

endmodule

// File: rtl/shape_raster.sv
// Turns a line/rect trigger into a stream of pixel coordinates;
// lines use line_stepper, rectangles are walked edge by edge here.
module shape_raster #(
    parameter int COORD_W = draw_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic               abort,
    shape_raster_if.master     px,
    output logic               busy,
    output logic               done
);

    import draw_pkg::*;

    state_t             state;
    logic [1:0]         cmode;
    logic [COORD_W-1:0] cax;
    logic [COORD_W-1:0] cay;
    logic [COORD_W-1:0] cbx;
    logic [COORD_W-1:0] cby;
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic [COORD_W-1:0] ls_x;
    logic [COORD_W-1:0] ls_y;
    logic               ls_end;
    logic               ls_load;
    logic               ls_step;
    logic               px_valid_q;
    logic               accept;
    logic [COORD_W-1:0] rx_lo;
    logic [COORD_W-1:0] rx_hi;
    logic [COORD_W-1:0] ry_lo;
    logic [COORD_W-1:0] ry_hi;

    assign rx_lo = (cax < cbx) ? cax : cbx;
    assign rx_hi = (cax < cbx) ? cbx : cax;
    assign ry_lo = (cay < cby) ? cay : cby;
    assign ry_hi = (cay < cby) ? cby : cay;

    assign accept  = px_valid_q & px.px_ready;
    assign ls_load = (state == SETUP);
    assign ls_step = (state == LINE) & accept & ~ls_end & ~abort;

    line_stepper #(
        .W (COORD_W)
    ) u_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ls_load),
        .step   (ls_step),
        .x0     (cax),
        .y0     (cay),
        .x1     (cbx),
        .y1     (cby),
        .x      (ls_x),
        .y      (ls_y),
        .at_end (ls_end)
    );

    // Both cursors are registers, so the select only picks a stable source.
    assign px.px_x     = (state == LINE) ? ls_x : cx;
    assign px.px_y     = (state == LINE) ? ls_y : cy;
    assign px.px_valid = px_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmode      <= MODE_FREEHAND;
            cax        <= '0;
            cay        <= '0;
            cbx        <= '0;
            cby        <= '0;
            xmin       <= '0;
            xmax       <= '0;
            ymin       <= '0;
            ymax       <= '0;
            cx         <= '0;
            cy         <= '0;
            px_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state      <= IDLE;
                px_valid_q <= 1'b0;
                busy       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && (mode == MODE_LINE || mode == MODE_RECT)) begin
                            cmode <= mode;
                            cax   <= ax;
                            cay   <= ay;
                            cbx   <= bx;
                            cby   <= by;
                            busy  <= 1'b1;
                            state <= SETUP;
                        end
                    end
                    SETUP: begin
                        px_valid_q <= 1'b1;
                        if (cmode == MODE_LINE) begin
                            state <= LINE;
                        end else begin
                            xmin  <= rx_lo;
                            xmax  <= rx_hi;
                            ymin  <= ry_lo;
                            ymax  <= ry_hi;
                            cx    <= rx_lo;
                            cy    <= ry_lo;
                            state <= R_TOP;
                        end
                    end
                    LINE: begin
                        if (accept && ls_end) begin
                            px_valid_q <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= FIN;
                        end
                    end
                    R_TOP: begin
                        if (accept) begin
                            if (cx != xmax) begin
                                cx <= cx + 1'b1;
                            end else if (ymax != ymin) begin
                                cy    <= ymin + 1'b1;
                                state <= R_RIGHT;
                            end else begin
                                px_valid_q <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                state      <= FIN;
                            end
                        end
                    end
                    R_RIGHT: begin
                        if (accept) begin
                            if (cy != ymax) begin
                                cy <= cy + 1'b1;
                            end else if (xmax != xmin) begin
                                cx    <= xmax - 1'b1;
                                state <= R_BOT;
                            end else begin
                                px_valid_q <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                state      <= FIN;
                            end
                        end
                    end
                    R_BOT: begin
                        if (accept) begin
                            if (cx != xmin) begin
                                cx <= cx - 1'b1;
                            end else if ((ymax - ymin) > COORD_W'(1)) begin
                                cy    <= ymax - 1'b1;
                                state <= R_LEFT;
                            end else begin
                                px_valid_q <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                state      <= FIN;
                            end
                        end
                    end
                    R_LEFT: begin
                        if (accept) begin
                            if (cy != ymin + 1'b1) begin
                                cy <= cy - 1'b1;
                            end else begin
                                px_valid_q <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                state      <= FIN;
                            end
                        end
                    end
                    FIN: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shape_raster.sv
// Directed bench for shape_raster: lines, rects, backpressure, ignored
// triggers, extremes, abort and asynchronous reset.
module tb_shape_raster;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic [7:0] ax    = '0;
    logic [7:0] ay    = '0;
    logic [7:0] bx    = '0;
    logic [7:0] by    = '0;
    logic       busy;
    logic       done;

    shape_raster_if #(.W(8)) pxi ();

    shape_raster #(
        .COORD_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .ax    (ax),
        .ay    (ay),
        .bx    (bx),
        .by    (by),
        .abort (abort),
        .px    (pxi),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    logic        done_seen;
    logic        busy_at_done;
    logic        valid_at_done;
    int          done_c;
    int          last_c;
    int          ndone;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fire(input logic [1:0] m, input logic [7:0] a_x,
                        input logic [7:0] a_y, input logic [7:0] b_x,
                        input logic [7:0] b_y);
        start = 1'b1;
        mode  = m;
        ax    = a_x;
        ay    = a_y;
        bx    = b_x;
        by    = b_y;
        tick();
        start = 1'b0;
    endtask

    // Records accepted pixels until done or the cycle budget runs out.
    task automatic collect(input int budget);
        done_seen     = 1'b0;
        busy_at_done  = 1'b1;
        valid_at_done = 1'b1;
        done_c        = -1;
        last_c        = -1;
        for (int c = 0; c < budget; c++) begin
            if (pxi.px_valid && pxi.px_ready) begin
                got.push_back({pxi.px_x, pxi.px_y});
                last_c = c;
            end
            if (done) begin
                done_seen     = 1'b1;
                done_c        = c;
                busy_at_done  = busy;
                valid_at_done = pxi.px_valid;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic check_end(input string tag);
        chk({tag, "_done"}, 32'(done_seen), 32'd1);
        chk({tag, "_done_lat"}, 32'(done_c - last_c), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
        chk({tag, "_valid_at_done"}, 32'(valid_at_done), 32'd0);
    endtask

    task automatic check_seq(input string tag);
        logic [31:0] obs;
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got.size()) ? {16'h0, got[i]} : 32'hDEAD_BEEF;
            chk($sformatf("%s_px%0d", tag, i), obs, {16'h0, exp_q[i]});
        end
    endtask

    initial begin
        pxi.px_ready = 1'b1;

        // reset values
        tick();
        tick();
        chk("rst_valid", 32'(pxi.px_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_x", 32'(pxi.px_x), 32'd0);
        chk("rst_y", 32'(pxi.px_y), 32'd0);
        rst_n = 1'b1;
        tick();

        // line (10,10)->(13,12) with latency
        got.delete();
        fire(2'd1, 8'd10, 8'd10, 8'd13, 8'd12);
        chk("l1_setup_busy", 32'(busy), 32'd1);
        chk("l1_setup_valid", 32'(pxi.px_valid), 32'd0);
        tick();
        chk("l1_first_valid", 32'(pxi.px_valid), 32'd1);
        collect(20);
        exp_q = '{16'h0A0A, 16'h0B0B, 16'h0C0B, 16'h0D0C};
        check_seq("l1");
        check_end("l1");

        // rect A=(4,5) B=(2,3)
        got.delete();
        fire(2'd2, 8'd4, 8'd5, 8'd2, 8'd3);
        tick();
        collect(30);
        exp_q = '{16'h0203, 16'h0303, 16'h0403, 16'h0404,
                  16'h0405, 16'h0305, 16'h0205, 16'h0204};
        check_seq("r1");
        check_end("r1");

        // degenerate rect A=(7,1) B=(7,4)
        got.delete();
        fire(2'd2, 8'd7, 8'd1, 8'd7, 8'd4);
        tick();
        collect(20);
        exp_q = '{16'h0701, 16'h0702, 16'h0703, 16'h0704};
        check_seq("r2");
        check_end("r2");

        // backpressure on second pixel of (0,0)->(5,0)
        got.delete();
        fire(2'd1, 8'd0, 8'd0, 8'd5, 8'd0);
        tick();
        got.push_back({pxi.px_x, pxi.px_y});
        tick();
        pxi.px_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i),
                {15'h0, pxi.px_valid, pxi.px_x, pxi.px_y},
                {15'h0, 1'b1, 8'd1, 8'd0});
        end
        pxi.px_ready = 1'b1;
        collect(20);
        exp_q = '{16'h0000, 16'h0100, 16'h0200,
                  16'h0300, 16'h0400, 16'h0500};
        check_seq("bp");
        check_end("bp");

        // ignored modes
        fire(2'd0, 8'd1, 8'd1, 8'd9, 8'd9);
        chk("m0_busy", 32'(busy), 32'd0);
        tick();
        chk("m0_valid", 32'(pxi.px_valid), 32'd0);
        fire(2'd3, 8'd1, 8'd1, 8'd9, 8'd9);
        chk("m3_busy", 32'(busy), 32'd0);
        tick();
        chk("m3_valid", 32'(pxi.px_valid), 32'd0);

        // start while busy is ignored, inputs changed afterwards
        got.delete();
        fire(2'd1, 8'd20, 8'd20, 8'd23, 8'd20);
        start = 1'b1;
        mode  = 2'd2;
        ax    = 8'd100;
        ay    = 8'd100;
        bx    = 8'd110;
        by    = 8'd110;
        tick();
        start = 1'b0;
        collect(20);
        exp_q = '{16'h1414, 16'h1514, 16'h1614, 16'h1714};
        check_seq("sb");
        check_end("sb");

        // anti-diagonal extreme
        got.delete();
        fire(2'd1, 8'd255, 8'd0, 8'd0, 8'd255);
        tick();
        collect(400);
        chk("diag_len", 32'(got.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== {8'(255 - i), 8'(i)}) bad++;
        end
        chk("diag_path", 32'(bad), 32'd0);
        chk("diag_last", (got.size() > 0) ? {16'h0, got[got.size()-1]}
                                          : 32'hDEAD_BEEF, 32'h0000_00FF);
        check_end("diag");

        // single pixel line
        got.delete();
        fire(2'd1, 8'd9, 8'd9, 8'd9, 8'd9);
        tick();
        collect(10);
        exp_q = '{16'h0909};
        check_seq("pt");
        check_end("pt");

        // abort during rect after two accepts
        got.delete();
        fire(2'd2, 8'd0, 8'd0, 8'd3, 8'd3);
        tick();
        tick();
        tick();
        chk("ab_pre_x", 32'(pxi.px_x), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", 32'(pxi.px_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        ndone = 32'(done);
        for (int i = 0; i < 3; i++) begin
            tick();
            ndone += 32'(done);
        end
        chk("ab_no_done", 32'(ndone), 32'd0);
        fire(2'd1, 8'd1, 8'd1, 8'd2, 8'd2);
        tick();
        collect(10);
        exp_q = '{16'h0101, 16'h0202};
        check_seq("ab_next");
        check_end("ab_next");

        // asynchronous reset mid-line
        fire(2'd1, 8'd0, 8'd0, 8'd10, 8'd0);
        tick();
        tick();
        chk("mr_pre_x", 32'(pxi.px_x), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(pxi.px_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_xy", {16'h0, pxi.px_x, pxi.px_y}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mr_after_busy", 32'(busy), 32'd0);
        chk("mr_after_valid", 32'(pxi.px_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shape_raster.md
Name: shape_raster

Overview:
Consumer of the draw-mode controller's shape trigger. On a trigger it captures mode plus endpoints A/B and rasterizes the shape into a stream of pixel coordinates over a valid/ready handshake. The framebuffer write path sits downstream.
- Mode 1: Bresenham line, A to B inclusive.
- Mode 2: one-pixel rectangle outline with corners A and B.
- Modes 0 and 3: the trigger is ignored.

Parameters:
COORD_W, 8, coordinate width in bits (unsigned, 0..2^COORD_W-1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle trigger pulse; sampled only in IDLE
mode  in  2  draw mode: 0 freehand, 1 line, 2 rect, 3 spray
ax  in  COORD_W  point A x
ay  in  COORD_W  point A y
bx  in  COORD_W  point B x
by  in  COORD_W  point B y
abort  in  1  synchronous cancel of the current shape
px_x  out  COORD_W  pixel x
px_y  out  COORD_W  pixel y
px_valid  out  1  pixel available
px_ready  in  1  downstream accepts pixel
busy  out  1  shape in progress
done  out  1  one-cycle pulse when a shape completes

Behaviour:
- Reset values: px_x=0, px_y=0, px_valid=0, busy=0, done=0, FSM in IDLE. Reset mid-shape discards the shape with no done pulse.
- FSM states: IDLE, SETUP, LINE, R_TOP, R_RIGHT, R_BOT, R_LEFT, FIN.
- IDLE:
  - start=1 with mode 1 or 2: capture ax/ay/bx/by/mode, go to SETUP, busy=1 from the next cycle.
  - start with mode 0 or 3: no effect.
- start while not in IDLE is ignored. No queuing.
- SETUP (1 cycle):
  - Line: dx=|bx-ax|, dy=-|by-ay|, sx/sy=±1, err=dx+dy. Signed, COORD_W+2 bits.
  - Rect: xmin/xmax/ymin/ymax normalized from A and B.
- Latency: start sampled on edge N → SETUP during cycle N+1 → first px_valid in cycle N+2.
- Handshake:
  - px_x/px_y are stable while px_valid=1 and px_ready=0.
  - Advance only on px_valid&px_ready.
  - With px_ready held high, throughput is 1 pixel/cycle with no bubbles between rect edges.
- LINE:
  - Emit the current (x,y), starting at A.
  - On accept: if (x,y)==B, go to FIN. Otherwise e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy.
  - Pixel count is max(dx,|dy|)+1. A==B gives exactly one pixel.
  - Coordinates never wrap; the endpoint is reached exactly.
- RECT traversal, each pixel emitted exactly once:
  - R_TOP: (xmin..xmax, ymin).
  - R_RIGHT: (xmax, ymin+1..ymax).
  - R_BOT: (xmax-1 down to xmin, ymax); skipped if h==0 or w==0.
  - R_LEFT: (xmin, ymax-1 down to ymin+1); skipped if w==0 or h<2.
  - Empty edges are skipped in zero cycles.
  - Count: 2(w+h) when w,h>0; w+h+1 when degenerate (w=xmax-xmin, h=ymax-ymin).
- FIN: px_valid=0, done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- The earliest a new start is accepted is the cycle after FIN.
- abort=1 in any non-IDLE state: next cycle IDLE, px_valid=0, busy=0, no done. A pending unaccepted pixel is dropped.
- Simultaneous abort and accept: abort wins; the accepted pixel counts as consumed downstream.
- Inputs ax..by may change after the trigger with no effect (captured copies are used).

Decomposition:
- Shared package draw_pkg:
  - mode constants MODE_FREEHAND=0, MODE_LINE=1, MODE_RECT=2, MODE_SPRAY=3
  - COORD_W default
  - FSM state enum
- Sub-module line_stepper: Bresenham core (load, step, at_end, x/y outputs), reusable by future tools.
- Rectangle walking stays in shape_raster.

Test Plan:
1. Line A=(10,10) B=(13,12), px_ready=1 → pixels (10,10),(11,11),(12,11),(13,12); first px_valid 2 cycles after start; done 1 cycle after the last accept.
2. Rect A=(4,5) B=(2,3) → (2,3),(3,3),(4,3),(4,4),(4,5),(3,5),(2,5),(2,4); 8 pixels, no repeats. Degenerate A=(7,1) B=(7,4) → (7,1),(7,2),(7,3),(7,4).
3. Backpressure: line (0,0)→(5,0) with px_ready low 3 cycles on the second pixel → (1,0) held stable, sequence unchanged, 6 pixels total.
4. start with mode 0 or 3 → busy stays 0, no px_valid. start during a busy line → ignored, original shape completes unchanged.
5. Extremes: line (255,0)→(0,255) → 256 pixels on the anti-diagonal, last (0,255), no wrap. A==B=(9,9) line → single pixel then done.
6. abort after 2 accepted pixels of rect (0,0)-(3,3) → px_valid=0 and busy=0 next cycle, no done; next start accepted normally. rst_n low mid-line → all outputs at reset values immediately.
